// File: rtl/rf_writeback_arbiter_if.sv
// rf_writeback_arbiter_if: execute/memory write-back streams, decode hazard lookup and register file write port.
interface rf_writeback_arbiter_if #(parameter int LQ_AW = 2);
  logic             i_alu_valid;
  logic [4:0]       i_alu_rd;
  logic [31:0]      i_alu_data;
  logic             i_ld_valid;
  logic             o_ld_ready;
  logic [4:0]       i_ld_rd;
  logic [31:0]      i_ld_data;
  logic             i_issue_valid;
  logic [4:0]       i_issue_rd;
  logic [4:0]       i_rs1_raddr;
  logic [4:0]       i_rs2_raddr;
  logic             o_rs1_busy;
  logic             o_rs2_busy;
  logic             o_rd_wen;
  logic [4:0]       o_rd_waddr;
  logic [31:0]      o_rd_wdata;
  logic [LQ_AW:0]   o_lq_count;
  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data, i_ld_valid, i_ld_rd, i_ld_data,
           i_issue_valid, i_issue_rd, i_rs1_raddr, i_rs2_raddr,
    input  o_ld_ready, o_rs1_busy, o_rs2_busy, o_rd_wen, o_rd_waddr, o_rd_wdata, o_lq_count
  );
  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data, i_ld_valid, i_ld_rd, i_ld_data,
           i_issue_valid, i_issue_rd, i_rs1_raddr, i_rs2_raddr,
    output o_ld_ready, o_rs1_busy, o_rs2_busy, o_rd_wen, o_rd_waddr, o_rd_wdata, o_lq_count
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges ALU results and queued load responses onto one register file write port,
// tracking outstanding loads so decode can stall on RAW hazards.
module rf_writeback_arbiter #(
  parameter int LQ_DEPTH = 4,
  parameter int LQ_AW    = 2
) (
  input logic i_clk,
  input logic i_rst,
  rf_writeback_arbiter_if.slave bus
);
  logic [4:0]       r_lq_rd   [LQ_DEPTH];
  logic [31:0]      r_lq_data [LQ_DEPTH];
  logic [LQ_AW-1:0] r_wptr;
  logic [LQ_AW-1:0] r_rptr;
  logic [LQ_AW:0]   r_count;
  logic [31:0]      r_pending;
  logic             r_wen;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;
  logic             w_ready;
  logic             w_alu_req;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_set;
  logic [31:0]      w_clr;
  assign w_ready   = r_count != (LQ_AW+1)'(LQ_DEPTH);
  assign w_alu_req = bus.i_alu_valid && bus.i_alu_rd != 5'd0;
  assign w_accept  = bus.i_ld_valid && w_ready;
  assign w_push    = w_accept && bus.i_ld_rd != 5'd0;
  assign w_pop     = !w_alu_req && r_count != '0;
  assign w_set     = bus.i_issue_valid ? 32'd1 << bus.i_issue_rd : 32'd0;
  assign w_clr     = w_pop ? 32'd1 << r_lq_rd[r_rptr] : 32'd0;
  always_ff @(posedge i_clk)
    if (w_push) begin
      r_lq_rd[r_wptr]   <= bus.i_ld_rd;
      r_lq_data[r_wptr] <= bus.i_ld_data;
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_wptr    <= r_wptr + LQ_AW'(w_push);
      r_rptr    <= r_rptr + LQ_AW'(w_pop);
      r_count   <= r_count + (LQ_AW+1)'(w_push) - (LQ_AW+1)'(w_pop);
      // set is applied after clear: a newly issued load to the same rd keeps it busy
      r_pending <= ((r_pending & ~w_clr) | w_set) & ~32'd1;
      r_wen     <= w_alu_req || w_pop;
      if (w_alu_req) begin
        r_waddr <= bus.i_alu_rd;
        r_wdata <= bus.i_alu_data;
      end else if (w_pop) begin
        r_waddr <= r_lq_rd[r_rptr];
        r_wdata <= r_lq_data[r_rptr];
      end
    end
  assign bus.o_ld_ready = w_ready;
  assign bus.o_lq_count = r_count;
  assign bus.o_rs1_busy = r_pending[bus.i_rs1_raddr];
  assign bus.o_rs2_busy = r_pending[bus.i_rs2_raddr];
  assign bus.o_rd_wen   = r_wen;
  assign bus.o_rd_waddr = r_waddr;
  assign bus.o_rd_wdata = r_wdata;
endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Writer-side companion to the core register file. Merges the single-cycle ALU result stream and the variable-latency load-response stream into the register file's single write port.
- Buffers load responses in a small FIFO; the ALU always has priority.
- Keeps a pending-load scoreboard so decode can stall on RAW hazards against loads that have not yet written back.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- LQ_DEPTH, 4, load-queue entries; power of two, >= 2.
- LQ_AW, 2, load-queue pointer width; must equal log2(LQ_DEPTH).

Ports:
- i_clk  in  1  global clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_alu_valid  in  1  ALU result valid this cycle; no backpressure.
- i_alu_rd  in  5  ALU destination register.
- i_alu_data  in  32  ALU result.
- i_ld_valid  in  1  load response valid.
- o_ld_ready  out  1  load queue can accept a response.
- i_ld_rd  in  5  load destination register.
- i_ld_data  in  32  load data.
- i_issue_valid  in  1  a load is issued this cycle; marks rd pending.
- i_issue_rd  in  5  destination of the issued load.
- i_rs1_raddr  in  5  decode source 1 address.
- i_rs2_raddr  in  5  decode source 2 address.
- o_rs1_busy  out  1  source 1 has an outstanding load.
- o_rs2_busy  out  1  source 2 has an outstanding load.
- o_rd_wen  out  1  register file write enable (registered).
- o_rd_waddr  out  5  register file write address (registered).
- o_rd_wdata  out  32  register file write data (registered).
- o_lq_count  out  LQ_AW+1  current load-queue occupancy.

Behaviour:
- Reset (async assert, sampled deassert):
  - o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0.
  - Queue empty, o_lq_count=0, o_ld_ready=1.
  - All pending bits cleared, so o_rs*_busy=0.
  - Reset mid-operation discards all queued entries and all pending state.
- Load accept: a transfer occurs when i_ld_valid && o_ld_ready.
  - o_ld_ready = (count != LQ_DEPTH), driven from registered count only.
  - No same-cycle pass-through: a full queue stays not-ready even when a pop happens that cycle.
- Loads with i_ld_rd==0 are accepted and dropped: not enqueued, no write.
- Queue is FIFO. Read and write pointers wrap modulo LQ_DEPTH. Push and pop in the same cycle leave count unchanged.
- Write-port arbitration, evaluated each cycle and registered to the outputs (1-cycle latency from input to o_rd_*):
  - If i_alu_valid && i_alu_rd!=0: o_rd_wen=1, o_rd_waddr/o_rd_wdata take the ALU values. The queue does not pop.
  - Else if the queue is non-empty: pop the head; o_rd_wen=1 with the head's rd and data.
  - Else: o_rd_wen=0. o_rd_waddr/o_rd_wdata hold their previous values.
- An ALU result with rd==0 is treated as no request; the queue may pop that cycle.
- Minimum latency for a load that arrives at an empty queue, with no ALU traffic:
  - accepted at cycle N,
  - popped at cycle N+1,
  - o_rd_wen asserted after the edge ending cycle N+1.
- Scoreboard: pending[31:0]; pending[0] is hard 0.
  - Set: i_issue_valid && i_issue_rd!=0 sets pending[i_issue_rd] at the clock edge.
  - Clear: a queue pop clears pending[head.rd] at the same edge that registers the write.
  - Set and clear of the same index in the same cycle: set wins, because a newer load to that register is in flight.
  - ALU writes never touch the scoreboard.
- o_rs1_busy = pending[i_rs1_raddr] and o_rs2_busy = pending[i_rs2_raddr]; both combinational from registered state. An address of 0 always reads not-busy.
- Busy does not deassert until the edge at which the load's write is registered. With the register file bypass disabled, decode may read the value one cycle after busy drops.
- Overflow cannot occur. The upstream memory stage holds i_ld_valid, i_ld_rd and i_ld_data stable until the transfer occurs.

Test Plan:
- Reset: assert i_rst asynchronously mid-cycle with 2 queued loads and pending[5]=1.
  - Required: o_rd_wen=0, o_lq_count=0, o_ld_ready=1 and o_rs1_busy=0 for i_rs1_raddr=5, immediately, before the next edge.
- Basic load: issue rd=7, then load response rd=7/data=0xDEADBEEF.
  - Required: o_rs1_busy=1 for i_rs1_raddr=7 until the write edge.
  - Required: o_rd_wen=1, o_rd_waddr=7, o_rd_wdata=0xDEADBEEF two edges after acceptance.
  - Required: busy=0 after that edge.
- ALU priority: ALU valid for 4 consecutive cycles (rd=1..4) while loads rd=10,11 queue.
  - Required: writes occur in the order 1, 2, 3, 4, 10, 11.
  - Required: o_lq_count peaks at 2.
- Full queue: with ALU valid every cycle, push 4 loads.
  - Required: o_ld_ready=0 and o_lq_count=4.
  - Required: a fifth i_ld_valid is held until the ALU idles, and one pop restores o_ld_ready=1.
  - Required: FIFO order is preserved across pointer wrap-around over 9 pushes.
- x0 handling:
  - Load response with rd=0, data=0x1234: accepted, o_lq_count unchanged, no write.
  - ALU rd=0 while the queue is non-empty: the queue pops that cycle.
  - Issue rd=0: o_rs1_busy=0 for i_rs1_raddr=0.
- Set/clear collision: pop of a load to rd=9 in the same cycle as i_issue_valid with rd=9.
  - Required: pending[9] remains 1 after the edge, so o_rs2_busy=1 for i_rs2_raddr=9.
